// File: rtl/dt_repack.sv
// Thresholds an 8-bit distance map read from the result RAM and repacks it,
// 16 pixels per word (MSB = leftmost), into an sti-format word RAM.
module dt_repack #(
  parameter int unsigned PIX_NUM = 16384,
  parameter int unsigned RES_AW  = 14,
  parameter int unsigned STI_AW  = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        thresh,
  output logic              res_rd,
  output logic [RES_AW-1:0] res_addr,
  input  logic [7:0]        res_di,
  output logic              sti_wr,
  output logic [STI_AW-1:0] sti_addr,
  output logic [15:0]       sti_do,
  output logic [14:0]       obj_cnt,
  output logic              done
);

  localparam int unsigned WORD_W = 16;
  localparam int unsigned CNT_W  = 15;

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_e;

  state_e              state_q, state_d;
  logic                res_rd_q, res_rd_d;
  logic [RES_AW-1:0]   res_addr_q, res_addr_d;
  logic                sti_wr_q, sti_wr_d;
  logic [STI_AW-1:0]   sti_addr_q, sti_addr_d;
  logic [WORD_W-1:0]   sti_do_q, sti_do_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                done_q, done_d;
  logic [7:0]          thr_q, thr_d;
  logic [WORD_W-2:0]   sr_q, sr_d;
  logic                capture;
  logic                pix_bit;

  // res_addr_q always names the pixel whose data is on res_di this cycle
  assign pix_bit = (res_di > thr_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      res_rd_q   <= 1'b0;
      res_addr_q <= '0;
      sti_wr_q   <= 1'b0;
      sti_addr_q <= '0;
      sti_do_q   <= '0;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      thr_q      <= '0;
      sr_q       <= '0;
    end else begin
      state_q    <= state_d;
      res_rd_q   <= res_rd_d;
      res_addr_q <= res_addr_d;
      sti_wr_q   <= sti_wr_d;
      sti_addr_q <= sti_addr_d;
      sti_do_q   <= sti_do_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      thr_q      <= thr_d;
      sr_q       <= sr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    res_rd_d   = res_rd_q;
    res_addr_d = res_addr_q;
    sti_wr_d   = 1'b0;
    sti_addr_d = sti_addr_q;
    sti_do_d   = sti_do_q;
    cnt_d      = cnt_q;
    done_d     = done_q;
    thr_d      = thr_q;
    sr_d       = sr_q;
    capture    = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d    = READ;
          res_rd_d   = 1'b1;
          res_addr_d = '0;
          cnt_d      = '0;
          done_d     = 1'b0;
          thr_d      = thresh;
          sr_d       = '0;
        end else if (state_q == DONE) begin
          done_d = 1'b1;
        end
      end
      READ: begin
        capture    = 1'b1;
        res_addr_d = res_addr_q + RES_AW'(1);
        if (res_addr_q == RES_AW'(PIX_NUM - 2)) state_d = DRAIN;
      end
      DRAIN: begin
        capture  = 1'b1;
        res_rd_d = 1'b0;
        state_d  = DONE;
      end
      default: state_d = IDLE;
    endcase

    // Shift in from the LSB so the first pixel of a word ends up at bit 15
    if (capture) begin
      sr_d = {sr_q[WORD_W-3:0], pix_bit};
      if (pix_bit) cnt_d = cnt_q + CNT_W'(1);
      if (&res_addr_q[3:0]) begin
        sti_wr_d   = 1'b1;
        sti_addr_d = STI_AW'(res_addr_q >> 4);
        sti_do_d   = {sr_q, pix_bit};
      end
    end
  end

  assign res_rd   = res_rd_q;
  assign res_addr = res_addr_q;
  assign sti_wr   = sti_wr_q;
  assign sti_addr = sti_addr_q;
  assign sti_do   = sti_do_q;
  assign obj_cnt  = cnt_q;
  assign done     = done_q;

endmodule

// File: tb/tb_dt_repack.sv
// Directed bench for dt_repack: a combinational result-RAM model feeds the DUT,
// a negedge monitor records sti writes and the read-address stream.
module tb_dt_repack;

  localparam int unsigned PIX_NUM = 16384;
  localparam int unsigned RES_AW  = 14;
  localparam int unsigned STI_AW  = 10;
  localparam int unsigned NWORD   = 1024;
  localparam int          LAT     = 16385;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [7:0]        thresh;
  logic              res_rd;
  logic [RES_AW-1:0] res_addr;
  logic [7:0]        res_di;
  logic              sti_wr;
  logic [STI_AW-1:0] sti_addr;
  logic [15:0]       sti_do;
  logic [14:0]       obj_cnt;
  logic              done;

  dt_repack #(.PIX_NUM(PIX_NUM), .RES_AW(RES_AW), .STI_AW(STI_AW)) dut (
    .clk(clk), .reset(reset), .start(start), .thresh(thresh),
    .res_rd(res_rd), .res_addr(res_addr), .res_di(res_di),
    .sti_wr(sti_wr), .sti_addr(sti_addr), .sti_do(sti_do),
    .obj_cnt(obj_cnt), .done(done)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [PIX_NUM];
  assign res_di = mem[res_addr];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int                wr_count, order_bad, first_wr_cyc, gap_cnt, rd_cnt;
  logic [15:0]       wr_data [NWORD];
  logic              rd_first;
  logic [RES_AW-1:0] prev_addr;

  always @(negedge clk) begin
    if (sti_wr) begin
      if (wr_count == 0) first_wr_cyc = cyc;
      if (sti_addr != STI_AW'(wr_count)) order_bad++;
      wr_data[sti_addr] = sti_do;
      wr_count++;
    end
    if (res_rd) begin
      if (!rd_first && res_addr != RES_AW'(prev_addr + 1'b1)) gap_cnt++;
      rd_first  = 1'b0;
      prev_addr = res_addr;
      rd_cnt++;
    end
  end

  task automatic clear_mon();
    wr_count = 0; order_bad = 0; gap_cnt = 0; rd_cnt = 0;
    rd_first = 1'b1; first_wr_cyc = -1;
    for (int w = 0; w < NWORD; w++) wr_data[w] = 16'hDEAD;
  endtask

  task automatic fill_mem(input logic [7:0] v);
    for (int p = 0; p < PIX_NUM; p++) mem[p] = v;
  endtask

  task automatic set_sparse();
    fill_mem(8'h00);
    mem[129] = 8'd1; mem[130] = 8'd2; mem[131] = 8'd1; mem[144] = 8'd5;
  endtask

  // Launch a pass; optionally pulse start again so it lands on edge E(ign_at)
  task automatic run_pass(input logic [7:0] t, input int ign_at, output int c0,
                          output int lat, output logic ac_rd, output logic ac_done,
                          output logic [14:0] ac_cnt, output logic [RES_AW-1:0] ac_addr);
    @(negedge clk); #1;
    clear_mon();
    thresh = t; start = 1'b1; c0 = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    ac_rd = res_rd; ac_done = done; ac_cnt = obj_cnt; ac_addr = res_addr;
    lat = -1;
    for (int i = 0; i < 20000; i++) begin
      if (done) begin lat = cyc - c0; break; end
      start = (ign_at >= 0 && cyc == c0 + ign_at - 1);
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    fill_mem(8'h00);
    reset = 1'b1; start = 1'b0; thresh = 8'h00;
    repeat (3) @(negedge clk);
    checks++;
    if ({res_rd, res_addr, sti_wr, sti_addr, sti_do, obj_cnt, done} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: rd=%b addr=%0d wr=%b waddr=%0d do=%h cnt=%0d done=%b, want all 0",
               res_rd, res_addr, sti_wr, sti_addr, sti_do, obj_cnt, done);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({res_rd, done, sti_wr} !== 3'b000) begin
      errors++;
      $display("FAIL idle_after_reset: rd=%b done=%b wr=%b, want 0 0 0", res_rd, done, sti_wr);
    end
  endtask

  task automatic test_zero_map_ignored_start();
    int c0, lat, bad;
    logic ar, ad; logic [14:0] ac; logic [RES_AW-1:0] aa;
    fill_mem(8'h00);
    run_pass(8'h00, 500, c0, lat, ar, ad, ac, aa);
    checks++;
    if (ar !== 1'b1 || aa !== '0) begin
      errors++; $display("FAIL zero_accept: rd=%b addr=%0d, want 1 0", ar, aa);
    end
    checks++;
    if (lat !== LAT) begin errors++; $display("FAIL zero_latency: got %0d want %0d", lat, LAT); end
    checks++;
    if (first_wr_cyc !== c0 + 16) begin
      errors++; $display("FAIL zero_first_write: got cycle %0d want %0d", first_wr_cyc - c0, 16);
    end
    checks++;
    if (wr_count !== NWORD || order_bad !== 0) begin
      errors++; $display("FAIL zero_writes: count=%0d out_of_order=%0d, want %0d 0", wr_count, order_bad, NWORD);
    end
    checks++;
    if (gap_cnt !== 0 || rd_cnt !== PIX_NUM) begin
      errors++; $display("FAIL zero_addr_stream: gaps=%0d reads=%0d, want 0 %0d", gap_cnt, rd_cnt, PIX_NUM);
    end
    bad = 0;
    for (int w = 0; w < NWORD; w++) if (wr_data[w] !== 16'h0000) bad++;
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL zero_words: %0d words not 0000, want 0", bad); end
    checks++;
    if (obj_cnt !== 15'd0) begin errors++; $display("FAIL zero_cnt: got %0d want 0", obj_cnt); end
  endtask

  task automatic test_all_ones();
    int c0, lat, bad;
    logic ar, ad; logic [14:0] ac; logic [RES_AW-1:0] aa;
    fill_mem(8'hFF);
    run_pass(8'hFE, -1, c0, lat, ar, ad, ac, aa);
    checks++;
    if (lat !== LAT || wr_count !== NWORD) begin
      errors++; $display("FAIL ones_fe_pass: lat=%0d writes=%0d, want %0d %0d", lat, wr_count, LAT, NWORD);
    end
    bad = 0;
    for (int w = 0; w < NWORD; w++) if (wr_data[w] !== 16'hFFFF) bad++;
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL ones_fe_words: %0d words not FFFF, want 0", bad); end
    checks++;
    if (obj_cnt !== 15'd16384) begin errors++; $display("FAIL ones_fe_cnt: got %0d want 16384", obj_cnt); end
    // Restart from DONE with the highest threshold: nothing can exceed it
    run_pass(8'hFF, -1, c0, lat, ar, ad, ac, aa);
    checks++;
    if (ad !== 1'b0 || ac !== 15'd0 || ar !== 1'b1) begin
      errors++; $display("FAIL restart_accept: done=%b cnt=%0d rd=%b, want 0 0 1", ad, ac, ar);
    end
    checks++;
    if (lat !== LAT || wr_count !== NWORD) begin
      errors++; $display("FAIL ones_ff_pass: lat=%0d writes=%0d, want %0d %0d", lat, wr_count, LAT, NWORD);
    end
    bad = 0;
    for (int w = 0; w < NWORD; w++) if (wr_data[w] !== 16'h0000) bad++;
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL ones_ff_words: %0d words not 0000, want 0", bad); end
    checks++;
    if (obj_cnt !== 15'd0) begin errors++; $display("FAIL ones_ff_cnt: got %0d want 0", obj_cnt); end
  endtask

  task automatic test_sparse_thresh1();
    int c0, lat, bad;
    logic ar, ad; logic [14:0] ac; logic [RES_AW-1:0] aa;
    set_sparse();
    run_pass(8'd1, -1, c0, lat, ar, ad, ac, aa);
    checks++;
    if (wr_data[8] !== 16'h2000) begin errors++; $display("FAIL sparse1_word8: got %h want 2000", wr_data[8]); end
    checks++;
    if (wr_data[9] !== 16'h8000) begin errors++; $display("FAIL sparse1_word9: got %h want 8000", wr_data[9]); end
    bad = 0;
    for (int w = 0; w < NWORD; w++) if (w != 8 && w != 9 && wr_data[w] !== 16'h0000) bad++;
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL sparse1_others: %0d words not 0000, want 0", bad); end
    checks++;
    if (obj_cnt !== 15'd2) begin errors++; $display("FAIL sparse1_cnt: got %0d want 2", obj_cnt); end
  endtask

  task automatic test_reset_mid_pass();
    int c0, lat, bad;
    logic ar, ad; logic [14:0] ac; logic [RES_AW-1:0] aa;
    logic found;
    set_sparse();
    @(negedge clk); #1;
    clear_mon();
    thresh = 8'h00; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 3000 && !found; i++) begin
      @(negedge clk); #1;
      if (sti_wr && sti_addr == STI_AW'(100)) found = 1'b1;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL midreset_reach_write100: got not seen want seen"); end
    reset = 1'b1;
    #1;
    checks++;
    if ({res_rd, res_addr, sti_wr, sti_addr, sti_do, obj_cnt, done} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: rd=%b addr=%0d wr=%b waddr=%0d do=%h cnt=%0d done=%b, want all 0",
               res_rd, res_addr, sti_wr, sti_addr, sti_do, obj_cnt, done);
    end
    @(negedge clk);
    reset = 1'b0;
    run_pass(8'h00, -1, c0, lat, ar, ad, ac, aa);
    checks++;
    if (lat !== LAT || wr_count !== NWORD || order_bad !== 0) begin
      errors++;
      $display("FAIL postreset_pass: lat=%0d writes=%0d out_of_order=%0d, want %0d %0d 0",
               lat, wr_count, order_bad, LAT, NWORD);
    end
    checks++;
    if (wr_data[8] !== 16'h7000) begin errors++; $display("FAIL postreset_word8: got %h want 7000", wr_data[8]); end
    checks++;
    if (wr_data[9] !== 16'h8000) begin errors++; $display("FAIL postreset_word9: got %h want 8000", wr_data[9]); end
    bad = 0;
    for (int w = 0; w < NWORD; w++) if (w != 8 && w != 9 && wr_data[w] !== 16'h0000) bad++;
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL postreset_others: %0d words not 0000, want 0", bad); end
    checks++;
    if (obj_cnt !== 15'd4) begin errors++; $display("FAIL postreset_cnt: got %0d want 4", obj_cnt); end
  endtask

  initial begin
    test_reset();
    test_zero_map_ignored_start();
    test_all_ones();
    test_sparse_thresh1();
    test_reset_mid_pass();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
